lif_neuron_ctrl: RTL and testbench

// Sequencer for one LIF accumulator. Shares the accumulator's single add port among
// N_SYN synaptic requesters (round-robin), injects periodic leak (sub_en), and on

---
 rtl/lif_neuron_ctrl.sv | 174 +++++++++++++++++
 tb/tb_lif_neuron_ctrl.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/lif_neuron_ctrl.sv
// Sequencer for one LIF accumulator: round-robin synaptic adds, periodic leak, fire and refractory.
// Optional build macro LIF_CTRL_STATS_EN adds saturating spike and dropped-add counters.
module lif_neuron_ctrl #(
    parameter int WIDTH       = 8,
    parameter int N_SYN       = 4,
    parameter int LEAK_PERIOD = 16,
    parameter int REFRAC_CYC  = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [N_SYN-1:0]       i_syn_req,
    input  logic [N_SYN*WIDTH-1:0] i_syn_weight,
    output logic [N_SYN-1:0]       o_syn_ack,
    input  logic [WIDTH-1:0]       i_leak_amt,
    input  logic                   i_thresh_hit,
    output logic                   o_add_en,
    output logic [WIDTH-1:0]       o_add,
    output logic                   o_sub_en,
    output logic [WIDTH-1:0]       o_sub,
    output logic                   o_load_reset,
    output logic                   o_spike_out,
    output logic                   o_refrac
`ifdef LIF_CTRL_STATS_EN
    ,
    output logic [15:0]            o_spike_count,
    output logic [15:0]            o_drop_count
`endif
);

    localparam int PTR_W  = $clog2(N_SYN);
    localparam int LEAK_W = $clog2(LEAK_PERIOD);
    localparam int RC_W   = (REFRAC_CYC > 1) ? $clog2(REFRAC_CYC) : 1;
    localparam logic [RC_W-1:0]   RC_INIT   = (REFRAC_CYC > 0) ? RC_W'(REFRAC_CYC - 1) : '0;
    localparam logic [LEAK_W-1:0] LEAK_LAST = LEAK_W'(LEAK_PERIOD - 1);
    localparam logic [PTR_W-1:0]  PTR_LAST  = PTR_W'(N_SYN - 1);

    typedef enum logic [1:0] {
        S_RUN    = 2'd0,
        S_FIRE   = 2'd1,
        S_REFRAC = 2'd2
    } state_t;

    state_t             r_state;
    logic [PTR_W-1:0]   r_rr_ptr;
    logic [LEAK_W-1:0]  r_leak_cnt;
    logic               r_leak_pend;
    logic [RC_W-1:0]    r_refrac_cnt;

    logic [N_SYN-1:0]   w_elig;
    logic               w_found;
    logic [PTR_W-1:0]   w_winner;
    logic [PTR_W-1:0]   w_next_ptr;
    logic [WIDTH-1:0]   w_win_weight;
    logic               w_wrap;
    logic               w_fire_now;

    function automatic logic [N_SYN-1:0] onehot(input logic [PTR_W-1:0] idx);
        logic [N_SYN-1:0] v;
        v = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

    // Requests already acked last cycle are masked so a held request is not granted twice.
    assign w_elig       = i_syn_req & ~o_syn_ack;
    assign w_wrap       = (r_leak_cnt == LEAK_LAST);
    assign w_fire_now   = (r_state == S_RUN) && i_thresh_hit;
    assign w_next_ptr   = (w_winner == PTR_LAST) ? '0 : w_winner + 1'b1;
    assign w_win_weight = i_syn_weight[int'(w_winner)*WIDTH +: WIDTH];

    always_comb begin
        w_found  = 1'b0;
        w_winner = '0;
        for (int k = 0; k < N_SYN; k++) begin
            if (!w_found && w_elig[(int'(r_rr_ptr) + k) % N_SYN]) begin
                w_found  = 1'b1;
                w_winner = PTR_W'((int'(r_rr_ptr) + k) % N_SYN);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state      <= S_RUN;
            r_rr_ptr     <= '0;
            r_leak_cnt   <= '0;
            r_leak_pend  <= 1'b0;
            r_refrac_cnt <= '0;
            o_syn_ack    <= '0;
            o_add_en     <= 1'b0;
            o_add        <= '0;
            o_sub_en     <= 1'b0;
            o_sub        <= '0;
            o_load_reset <= 1'b0;
            o_spike_out  <= 1'b0;
            o_refrac     <= 1'b0;
        end else begin
            r_leak_cnt   <= w_wrap ? '0 : r_leak_cnt + 1'b1;
            o_syn_ack    <= '0;
            o_add_en     <= 1'b0;
            o_sub_en     <= 1'b0;
            o_load_reset <= 1'b0;
            o_spike_out  <= 1'b0;
            case (r_state)
                S_RUN: begin
                    if (i_thresh_hit) begin
                        // A leak wrapping in this same cycle is discarded: the reload supersedes it.
                        r_state      <= S_FIRE;
                        o_load_reset <= 1'b1;
                        o_spike_out  <= 1'b1;
                        r_leak_pend  <= 1'b0;
                    end else if (r_leak_pend) begin
                        o_sub_en    <= 1'b1;
                        o_sub       <= i_leak_amt;
                        r_leak_pend <= w_wrap;
                    end else begin
                        r_leak_pend <= w_wrap;
                        if (w_found) begin
                            o_add_en  <= 1'b1;
                            o_add     <= w_win_weight;
                            o_syn_ack <= onehot(w_winner);
                            r_rr_ptr  <= w_next_ptr;
                        end
                    end
                end
                S_FIRE: begin
                    r_leak_pend <= w_wrap;
                    if (REFRAC_CYC > 0) begin
                        r_state      <= S_REFRAC;
                        r_refrac_cnt <= RC_INIT;
                        o_refrac     <= 1'b1;
                    end else begin
                        r_state <= S_RUN;
                    end
                end
                S_REFRAC: begin
                    r_leak_pend <= r_leak_pend | w_wrap;
                    if (r_refrac_cnt == '0) begin
                        r_state  <= S_RUN;
                        o_refrac <= 1'b0;
                    end else begin
                        r_refrac_cnt <= r_refrac_cnt - 1'b1;
                    end
                end
                default: begin
                    r_state <= S_RUN;
                end
            endcase
        end
    end

`ifdef LIF_CTRL_STATS_EN
    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    // An add still on the bus when the fire decision is made is wiped by the reload.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            o_spike_count <= '0;
            o_drop_count  <= '0;
        end else if (w_fire_now) begin
            o_spike_count <= sat_inc16(o_spike_count);
            if (o_add_en) begin
                o_drop_count <= sat_inc16(o_drop_count);
            end
        end
    end
`else
    logic w_unused_fire;
    assign w_unused_fire = w_fire_now;
`endif

endmodule

// File: tb/tb_lif_neuron_ctrl.sv
// Bench for lif_neuron_ctrl: directed scenarios plus randomized traffic against a
// cycle-count based reference model.
module tb_lif_neuron_ctrl;

    localparam int W  = 8;
    localparam int N  = 4;
    localparam int LP = 16;
    localparam int RC = 4;

    logic           clk;
    logic           rst_n;
    logic [N-1:0]   syn_req;
    logic [N*W-1:0] syn_weight;
    logic [N-1:0]   syn_ack;
    logic [W-1:0]   leak_amt;
    logic           thresh;
    logic           add_en;
    logic [W-1:0]   add;
    logic           sub_en;
    logic [W-1:0]   sub;
    logic           load_reset;
    logic           spike_out;
    logic           refrac;
`ifdef LIF_CTRL_STATS_EN
    logic [15:0]    spike_count;
    logic [15:0]    drop_count;
`endif

    lif_neuron_ctrl #(.WIDTH(W), .N_SYN(N), .LEAK_PERIOD(LP), .REFRAC_CYC(RC)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_syn_req    (syn_req),
        .i_syn_weight (syn_weight),
        .o_syn_ack    (syn_ack),
        .i_leak_amt   (leak_amt),
        .i_thresh_hit (thresh),
        .o_add_en     (add_en),
        .o_add        (add),
        .o_sub_en     (sub_en),
        .o_sub        (sub),
        .o_load_reset (load_reset),
        .o_spike_out  (spike_out),
        .o_refrac     (refrac)
`ifdef LIF_CTRL_STATS_EN
        ,
        .o_spike_count(spike_count),
        .o_drop_count (drop_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: cycles since reset, remaining busy cycles after a spike.
    int           m_cyc, m_busy, m_ptr, m_spikes, m_drops;
    bit           m_pend;
    logic [N-1:0] e_ack;
    logic         e_add_en, e_sub_en, e_load, e_spike, e_refrac;
    logic [W-1:0] e_add, e_sub;
    logic [N-1:0] ack_seen;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_cyc = 0; m_busy = 0; m_ptr = 0; m_pend = 0; m_spikes = 0; m_drops = 0;
        e_ack = '0; e_add_en = 0; e_sub_en = 0; e_load = 0; e_spike = 0; e_refrac = 0;
        e_add = '0; e_sub = '0;
    endtask

    task automatic model_step();
        bit           wrap;
        int           win;
        logic         prev_add_en;
        logic [N-1:0] prev_ack;
        wrap = (m_cyc % LP) == LP - 1;
        m_cyc++;
        prev_add_en = e_add_en;
        prev_ack    = e_ack;
        e_ack = '0; e_add_en = 0; e_sub_en = 0; e_load = 0; e_spike = 0;
        if (m_busy > 0) begin
            if (m_busy == RC + 1) m_pend = wrap;
            else                  m_pend = m_pend | wrap;
            m_busy--;
            e_refrac = (m_busy > 0);
        end else if (thresh) begin
            if (prev_add_en && m_drops < 65535) m_drops++;
            if (m_spikes < 65535) m_spikes++;
            e_load = 1; e_spike = 1; m_pend = 0; m_busy = RC + 1;
        end else if (m_pend) begin
            e_sub_en = 1; e_sub = leak_amt; m_pend = wrap;
        end else begin
            m_pend = wrap;
            win = -1;
            for (int k = 0; k < N; k++) begin
                int idx;
                idx = (m_ptr + k) % N;
                if (win < 0 && syn_req[idx] && !prev_ack[idx]) win = idx;
            end
            if (win >= 0) begin
                e_add_en = 1;
                e_add    = syn_weight[win*W +: W];
                e_ack[win] = 1'b1;
                m_ptr    = (win + 1) % N;
            end
        end
    endtask

    task automatic check_all();
        chk("ack", 32'(syn_ack), 32'(e_ack));
        chk("add_en", 32'(add_en), 32'(e_add_en));
        if (e_add_en) chk("add", 32'(add), 32'(e_add));
        chk("sub_en", 32'(sub_en), 32'(e_sub_en));
        if (e_sub_en) chk("sub", 32'(sub), 32'(e_sub));
        chk("load_reset", 32'(load_reset), 32'(e_load));
        chk("spike_out", 32'(spike_out), 32'(e_spike));
        chk("refrac", 32'(refrac), 32'(e_refrac));
`ifdef LIF_CTRL_STATS_EN
        chk("spike_count", 32'(spike_count), 32'(m_spikes));
        chk("drop_count", 32'(drop_count), 32'(m_drops));
`endif
    endtask

    task automatic tick();
        model_step();
        @(negedge clk);
        check_all();
    endtask

    task automatic do_reset(input int n);
        rst_n    = 1'b0;
        ack_seen = '0;
        for (int i = 0; i < n; i++) begin
            model_reset();
            @(negedge clk);
            check_all();
            chk("rst_add", 32'(add), 32'd0);
            chk("rst_sub", 32'(sub), 32'd0);
        end
        rst_n = 1'b1;
    endtask

    task automatic drive_auto();
        for (int i = 0; i < N; i++) begin
            if (ack_seen[i]) begin
                syn_req[i] = 1'b0;
            end else if (!syn_req[i] && $urandom_range(0, 3) == 0) begin
                syn_req[i] = 1'b1;
                syn_weight[i*W +: W] = W'($urandom);
            end
        end
        ack_seen = syn_ack;
        thresh   = ($urandom_range(0, 15) == 0);
        leak_amt = W'($urandom);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired checks=%0d", checks);
        $fatal(1);
    end

    initial begin
        int cnt_a, cnt_b;
        rst_n = 1'b0; syn_req = '0; syn_weight = '0; leak_amt = '0; thresh = 1'b0; ack_seen = '0;
        do_reset(2);

        // Round-robin over four held requests
        syn_req  = 4'hF;
        for (int i = 0; i < N; i++) syn_weight[i*W +: W] = W'(i + 1);
        leak_amt = 8'd3;
        for (int k = 0; k < 5; k++) begin
            tick();
            chk("rr_ack", 32'(syn_ack), 32'(1 << (k % 4)));
            chk("rr_add", 32'(add), 32'((k % 4) + 1));
        end
        tick();
        tick();
        do_reset(2);
        tick();
        chk("post_rst_ack", 32'(syn_ack), 32'd1);
        chk("post_rst_add", 32'(add), 32'd1);

        // Leak only
        syn_req = '0;
        cnt_a = 0; cnt_b = 0;
        repeat (48) begin
            tick();
            cnt_a += int'(sub_en);
            cnt_b += int'(add_en);
        end
        chk("leak_count", 32'(cnt_a), 32'd3);
        chk("leak_no_add", 32'(cnt_b), 32'd0);

        // Fire, refractory, pending request served on return to RUN
        thresh = 1'b1;
        tick();
        chk("fire_load", 32'(load_reset), 32'd1);
        chk("fire_spike", 32'(spike_out), 32'd1);
        thresh = 1'b0;
        syn_req = 4'b0100;
        syn_weight[2*W +: W] = 8'd9;
        cnt_a = 0; cnt_b = 0;
        repeat (RC + 1) begin
            tick();
            cnt_a += int'(refrac);
            cnt_b += int'(syn_ack != '0);
        end
        chk("refrac_len", 32'(cnt_a), 32'(RC));
        chk("refrac_no_ack", 32'(cnt_b), 32'd0);
        tick();
        chk("first_run_ack", 32'(syn_ack), 32'b0100);
        chk("first_run_add", 32'(add), 32'd9);
        syn_req = '0;

        // Leak wrap coinciding with thresh_hit
        for (int g = 0; g < LP; g++) if ((m_cyc % LP) != LP - 1) tick();
        thresh = 1'b1;
        tick();
        chk("coinc_load", 32'(load_reset), 32'd1);
        chk("coinc_no_sub", 32'(sub_en), 32'd0);
        thresh = 1'b0;
        cnt_a = 0;
        repeat (LP) begin
            tick();
            cnt_a += int'(sub_en);
        end
        chk("coinc_sub_dropped", 32'(cnt_a), 32'd0);
        tick();
        chk("coinc_next_wrap", 32'(sub_en), 32'd1);

        // Three spikes, the last with an add in flight
        do_reset(1);
        repeat (2) begin
            thresh = 1'b1;
            tick();
            thresh = 1'b0;
            repeat (RC + 1) tick();
        end
        syn_req = 4'b0001;
        syn_weight[0 +: W] = 8'd5;
        tick();
        chk("inflight_add", 32'(add_en), 32'd1);
        syn_req = '0;
        thresh = 1'b1;
        tick();
        chk("inflight_fire", 32'(load_reset), 32'd1);
        thresh = 1'b0;
        repeat (RC + 1) tick();
`ifdef LIF_CTRL_STATS_EN
        chk("stats_spikes", 32'(spike_count), 32'd3);
        chk("stats_drops", 32'(drop_count), 32'd1);
`endif

        // Randomized traffic with one reset in the middle
        for (int c = 0; c < 2000; c++) begin
            if (c == 1000) do_reset(2);
            drive_auto();
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
